// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: opcodes, fetch FSM states
// and the default boot address.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC selection for the fetch stage: jump beats taken branch beats sequential.
module next_pc_logic
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_index,
  input  logic [31:0] sign_imm,
  input  logic        jump,
  input  logic        branch_taken,
  output logic [31:0] next_pc
);

  logic [31:0] jump_target;
  logic [31:0] branch_target;

  assign jump_target   = {pc_plus4[31:28], instr_index, 2'b00};
  assign branch_target = pc_plus4 + {sign_imm[29:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time from
// instruction memory, presents it to decode and counts retired instructions.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ready,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  instr,
  output logic         instr_valid,
  output logic [31:0]  pc,
  output logic [31:0]  pc_plus4,
  input  logic         hold,
  input  logic         jump,
  input  logic         branch_taken,
  input  logic [31:0]  sign_imm,
  output logic [31:0]  instr_count,
  output fetch_state_e fsm_state
);

  // Memory handshake: a fetch transfers on the edge where imem_req and
  // imem_ready are both high; until then imem_req stays high and imem_addr
  // stays put. imem_ready/imem_rdata are ignored whenever imem_req is low.

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  count_q;
  logic [31:0]  next_pc;

  next_pc_logic u_next_pc (
    .pc_plus4     (pc_plus4),
    .instr_index  (instr_q[25:0]),
    .sign_imm     (sign_imm),
    .jump         (jump),
    .branch_taken (branch_taken),
    .next_pc      (next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && imem_ready) begin
        instr_q <= imem_rdata;
      end
      // Retirement: the redirect and the count only commit when decode releases hold.
      if (state_q == EXEC && !hold) begin
        pc_q    <= next_pc;
        count_q <= count_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (imem_ready) state_d = EXEC;
      EXEC:    if (!hold) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == EXEC);
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr_count = count_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the fetch/execute protocol.
module tb_fetch_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: default boot address
  logic         rst = 1'b1;
  logic         imem_ready = 1'b0;
  logic [31:0]  imem_rdata = 32'h0;
  logic         hold = 1'b0;
  logic         jump = 1'b0;
  logic         branch_taken = 1'b0;
  logic [31:0]  sign_imm = 32'h0;
  logic         imem_req, instr_valid;
  logic [31:0]  imem_addr, instr, pc, pc_plus4, instr_count;
  fetch_state_e dbg_a;

  // instance B: boot address at the top of memory
  logic         b_rst = 1'b1;
  logic         b_ready = 1'b0;
  logic [31:0]  b_rdata = 32'h0;
  logic         b_hold = 1'b0;
  logic         b_jump = 1'b0;
  logic         b_br = 1'b0;
  logic [31:0]  b_imm = 32'h0;
  logic         b_req, b_valid;
  logic [31:0]  b_addr, b_instr, b_pc, b_pc_plus4, b_count;
  fetch_state_e dbg_b;

  fetch_unit dut_a (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .hold(hold),
    .jump(jump), .branch_taken(branch_taken), .sign_imm(sign_imm),
    .instr_count(instr_count), .fsm_state(dbg_a)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(b_rst), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ready(b_ready), .imem_rdata(b_rdata), .instr(b_instr),
    .instr_valid(b_valid), .pc(b_pc), .pc_plus4(b_pc_plus4), .hold(b_hold),
    .jump(b_jump), .branch_taken(b_br), .sign_imm(b_imm),
    .instr_count(b_count), .fsm_state(dbg_b)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (instance A) ----------------
  // phase: 0 = waiting one cycle after reset, 1 = request outstanding, 2 = instruction held for decode
  int          m_phase = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_cnt = 32'h0;
  bit          m_live = 1'b0;

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic j, input logic b, input logic [31:0] imm);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (j) return (seq & 32'hF000_0000) | {4'b0, word[25:0], 2'b00};
    if (b) return seq + (imm << 2);
    return seq;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_pc = 32'h0; m_instr = 32'h0; m_cnt = 32'h0; m_live = 1'b1;
    end else if (m_live) begin
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (imem_ready) begin m_instr = imem_rdata; m_phase = 2; end
      end else if (!hold) begin
        m_pc = model_next(m_pc, m_instr, jump, branch_taken, sign_imm);
        m_cnt = m_cnt + 32'd1;
        m_phase = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("m_req", 32'(imem_req), 32'(m_phase == 1));
      check("m_valid", 32'(instr_valid), 32'(m_phase == 2));
      check("m_addr", imem_addr, m_pc);
      check("m_pc", pc, m_pc);
      check("m_pc_plus4", pc_plus4, m_pc + 32'd4);
      check("m_instr", instr, m_instr);
      check("m_count", instr_count, m_cnt);
      check("m_state_exec", 32'(dbg_a == EXEC), 32'(m_phase == 2));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; imem_ready = 1'b0; hold = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    repeat (n) cyc();
    rst = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] data, input int waits);
    logic [31:0] a;
    int budget;
    budget = 20;
    while (!imem_req && budget > 0) begin cyc(); budget--; end
    check("req_seen", 32'(imem_req), 32'd1);
    a = imem_addr;
    if (exp_q.size() > 0) check("fetch_addr", a, exp_q.pop_front());
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      cyc();
      check("addr_stable", imem_addr, a);
      check("req_held", 32'(imem_req), 32'd1);
    end
    imem_ready = 1'b1;
    imem_rdata = data;
    cyc();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    check("instr_word", instr, data);
    check("instr_valid", 32'(instr_valid), 32'd1);
    check("pc_of_instr", pc, a);
  endtask

  task automatic exec(input int holds, input logic j, input logic b, input logic [31:0] imm);
    logic [31:0] ki, kp, kc;
    ki = instr; kp = pc; kc = instr_count;
    hold = 1'b1;
    for (int i = 0; i < holds; i++) begin
      jump = 1'($urandom); branch_taken = 1'($urandom); sign_imm = $urandom;
      cyc();
      check("hold_instr", instr, ki);
      check("hold_pc", pc, kp);
      check("hold_count", instr_count, kc);
    end
    hold = 1'b0; jump = j; branch_taken = b; sign_imm = imm;
    cyc();
    jump = 1'b0; branch_taken = 1'b0;
    check("retire_count", instr_count, kc + 32'd1);
    check("refetch_req", 32'(imem_req), 32'd1);
  endtask

  initial begin
    // boot: reset values held during reset, then IDLE, FETCH, EXEC
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_pc_plus4", pc_plus4, 32'h4);
      check("rst_instr", instr, 32'h0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_count", instr_count, 32'h0);
    end
    rst = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h2002_0005;
    check("boot_c1_req", 32'(imem_req), 32'd0);
    cyc();
    check("boot_c2_req", 32'(imem_req), 32'd1);
    check("boot_c2_addr", imem_addr, 32'h0);
    cyc();
    imem_ready = 1'b0;
    check("boot_c3_valid", 32'(instr_valid), 32'd1);
    check("boot_c3_instr", instr, 32'h2002_0005);

    // sequential with two wait cycles per fetch
    do_reset(2);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    fetch(32'h8C01_0000, 2); exec(0, 1'b0, 1'b0, 32'h0);
    fetch(32'hAC01_0004, 2); exec(1, 1'b0, 1'b0, 32'h0);
    fetch(32'h0022_1820, 2); exec(0, 1'b0, 1'b0, 32'h0);
    check("seq_pc", pc, 32'hC);
    check("seq_addr", imem_addr, 32'hC);
    check("seq_count", instr_count, 32'd3);
    check("model_seq_pc", m_pc, 32'hC);

    // branches and jumps
    do_reset(1);
    exp_q.push_back(32'h0);
    fetch(32'h0800_0004, 0); exec(0, 1'b1, 1'b0, 32'h0);          // j to 0x10
    exp_q.push_back(32'h10);
    fetch(32'h1000_FFFE, 0); exec(0, 1'b0, 1'b1, 32'hFFFF_FFFE);  // back to 0x0C
    exp_q.push_back(32'h0C);
    fetch(32'h0800_0004, 0); exec(0, 1'b1, 1'b0, 32'h0);
    exp_q.push_back(32'h10);
    fetch(32'h1000_0003, 0); exec(0, 1'b0, 1'b1, 32'h3);          // forward to 0x20
    exp_q.push_back(32'h20);
    fetch(32'h1000_0007, 0); exec(2, 1'b0, 1'b1, 32'h0400_0007);  // to 0x1000_0040
    exp_q.push_back(32'h1000_0040);
    fetch(32'h0800_0010, 0); exec(0, 1'b1, 1'b1, 32'h0000_0005);  // jump wins
    exp_q.push_back(32'h1000_0040);
    fetch(32'h0000_0020, 1); exec(0, 1'b0, 1'b0, 32'h0);
    check("jb_count", instr_count, 32'd7);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    // reset in the same cycle memory answers
    do_reset(1);
    cyc();
    check("mf_req", 32'(imem_req), 32'd1);
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF; rst = 1'b1;
    cyc();
    rst = 1'b0; imem_ready = 1'b0;
    check("mf_instr", instr, 32'h0);
    check("mf_valid", 32'(instr_valid), 32'd0);
    check("mf_req_drop", 32'(imem_req), 32'd0);
    check("mf_addr", imem_addr, 32'h0);
    cyc();
    check("mf_restart_req", 32'(imem_req), 32'd1);
    check("mf_restart_addr", imem_addr, 32'h0);

    // hold and wrap on the instance booting at 0xFFFF_FFFC
    b_rst = 1'b0;
    cyc();
    check("w_req", 32'(b_req), 32'd1);
    check("w_addr", b_addr, 32'hFFFF_FFFC);
    check("w_pc_plus4", b_pc_plus4, 32'h0);
    b_ready = 1'b1; b_rdata = 32'h0BAD_F00D;
    cyc();
    b_ready = 1'b0;
    b_hold = 1'b1; b_jump = 1'b1; b_br = 1'b1; b_imm = 32'h40;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("w_hold_instr", b_instr, 32'h0BAD_F00D);
      check("w_hold_pc", b_pc, 32'hFFFF_FFFC);
      check("w_hold_count", b_count, 32'h0);
      check("w_hold_valid", 32'(b_valid), 32'd1);
    end
    b_hold = 1'b0; b_jump = 1'b0; b_br = 1'b0;
    cyc();
    check("w_next_addr", b_addr, 32'h0);
    check("w_count", b_count, 32'd1);
    check("w_req2", 32'(b_req), 32'd1);

    // random traffic, model-checked every cycle
    do_reset(1);
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] r;
      r = 16'($urandom);
      rst          = ($urandom_range(0, 63) == 0);
      imem_ready   = 1'($urandom_range(0, 1));
      imem_rdata   = $urandom;
      hold         = ($urandom_range(0, 2) == 0);
      jump         = ($urandom_range(0, 4) == 0);
      branch_taken = ($urandom_range(0, 2) == 0);
      sign_imm     = ($urandom_range(0, 1) == 1) ? {{16{r[15]}}, r} : $urandom;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
